// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with a running accumulator and valid/ready handshakes.
// S1 registers the operands; S2 computes, registers and holds result and flags for the consumer.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             zero,
  output logic             carry,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_ACC = 3'b111
  } op_e;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;
  logic             s1_clr;
  logic [WIDTH:0]   acc;

  logic             s1_load;
  logic             s2_load;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   acc_d;
  logic [WIDTH:0]   res_d;
  logic             carry_d;
  logic             ovf_d;

  // S2 takes S1's transaction whenever the output slot is empty or being drained.
  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !rst && (!s1_valid || !out_valid || out_ready);
  assign s1_load  = in_valid && in_ready;

  assign sh    = s1_b[SHW-1:0];
  assign a_ext = {1'b0, s1_a};
  assign sum   = a_ext + {1'b0, s1_b};
  assign diff  = a_ext - {1'b0, s1_b};
  assign acc_d = s1_clr ? a_ext : acc + a_ext;

  always_comb begin
    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res_d   = sum;
        carry_d = sum[WIDTH];
        ovf_d   = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = diff;
        carry_d = diff[WIDTH];
        ovf_d   = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_AND:  res_d = {1'b0, s1_a & s1_b};
      OP_OR:   res_d = {1'b0, s1_a | s1_b};
      OP_XOR:  res_d = {1'b0, s1_a ^ s1_b};
      OP_SHL:  res_d = a_ext << sh;
      OP_SHR:  res_d = {1'b0, s1_a >> sh};
      OP_ACC:  res_d = acc_d;
      default: res_d = '0;
    endcase
  end

  // NOTE: operand registers carry no reset; s1_valid alone decides whether they mean anything.
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_a   <= a;
      s1_b   <= b;
      s1_op  <= op_e'(opcode);
      s1_clr <= acc_clr;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use <= so every one samples pre-edge values in the same cycle.
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      acc       <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      // The accumulator commits with the S2 load, so a stalled ACC is applied exactly once.
      if (s2_load) begin
        out_valid <= 1'b1;
        result    <= res_d;
        zero      <= (res_d == '0);
        carry     <= carry_d;
        overflow  <= ovf_d;
        if (s1_op == OP_ACC) begin
          acc <= acc_d;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases plus randomized traffic with backpressure,
// checked against an arithmetic reference model evaluated in accept order.
module tb_alu_pipe;

  localparam int W = 8;
  localparam int EW = W + 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [2:0]     opcode = '0;
  logic           acc_clr = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W:0]     result;
  logic           zero;
  logic           carry;
  logic           overflow;

  int checks = 0;
  int errors = 0;
  int acc_m = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] ow(input logic [W:0] r, input logic z, input logic c,
                                      input logic o);
    return {r, z, c, o};
  endfunction

  function automatic int to_signed(input int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic logic [EW-1:0] model(input int op, input int aa, input int bb, input bit clr);
    int r;
    int s;
    bit c;
    bit o;
    logic [W:0] rr;
    int mask;
    mask = (1 << (W + 1)) - 1;
    c = 0;
    o = 0;
    r = 0;
    case (op)
      0: begin
        r = aa + bb;
        c = (r >= (1 << W));
        s = to_signed(aa) + to_signed(bb);
        o = (s >= (1 << (W - 1))) || (s < -(1 << (W - 1)));
      end
      1: begin
        r = (aa - bb) & mask;
        c = (aa < bb);
        s = to_signed(aa) - to_signed(bb);
        o = (s >= (1 << (W - 1))) || (s < -(1 << (W - 1)));
      end
      2: r = aa & bb;
      3: r = aa | bb;
      4: r = aa ^ bb;
      5: r = (aa << (bb % W)) & mask;
      6: r = aa >> (bb % W);
      default: begin
        acc_m = clr ? aa : (acc_m + aa) & mask;
        r = acc_m;
      end
    endcase
    rr = r[W:0];
    return ow(rr, (r == 0), c, o);
  endfunction

  // Negedge monitor: inputs and outputs are stable for the upcoming edge here.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      exp_q.delete();
      acc_m = 0;
    end else begin
      if (out_valid && out_ready) begin
        obs_q.push_back({result, zero, carry, overflow});
        if (exp_q.size() == 0) begin
          check("out_unexpected", 32'(result), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_result", 32'(result), 32'(e[EW-1:3]));
          check("out_flags", 32'({zero, carry, overflow}), 32'(e[2:0]));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(int'(opcode), int'(a), int'(b), acc_clr));
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                      input logic clr);
    int n;
    opcode   = op;
    a        = aa;
    b        = bb;
    acc_clr  = clr;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(n), 32'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n >= 200), 32'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic check_obs(input string tag, input int idx, input logic [EW-1:0] exp);
    check(tag, (obs_q.size() > idx) ? 32'(obs_q[idx]) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_result", 32'(result), 0);
    check("rst_flags", 32'({zero, carry, overflow}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;

    // ADD with carry, latency of two edges including the accept edge
    obs_q.delete();
    send(3'b000, 8'hF0, 8'h20, 1'b0);
    @(posedge clk);
    #1;
    check("add_out_valid", 32'(out_valid), 1);
    check("add_result", 32'(result), 32'h110);
    check("add_flags", 32'({zero, carry, overflow}), 32'b010);
    wait_drain("add_drain");

    // SUB overflow, borrow, zero
    obs_q.delete();
    send(3'b001, 8'h80, 8'h01, 1'b0);
    send(3'b001, 8'h03, 8'h04, 1'b0);
    send(3'b001, 8'h55, 8'h55, 1'b0);
    wait_drain("sub_drain");
    check("sub_count", 32'(obs_q.size()), 3);
    check_obs("sub_ovf", 0, ow(9'h07F, 1'b0, 1'b0, 1'b1));
    check_obs("sub_borrow", 1, ow(9'h1FF, 1'b0, 1'b1, 1'b0));
    check_obs("sub_zero", 2, ow(9'h000, 1'b1, 1'b0, 1'b0));

    // Back-to-back ACC
    obs_q.delete();
    send(3'b111, 8'h05, 8'h00, 1'b1);
    send(3'b111, 8'h07, 8'h00, 1'b0);
    send(3'b111, 8'hFF, 8'h00, 1'b0);
    send(3'b111, 8'h00, 8'h00, 1'b1);
    wait_drain("acc_drain");
    check("acc_count", 32'(obs_q.size()), 4);
    check_obs("acc_0", 0, ow(9'h005, 1'b0, 1'b0, 1'b0));
    check_obs("acc_1", 1, ow(9'h00C, 1'b0, 1'b0, 1'b0));
    check_obs("acc_2", 2, ow(9'h10B, 1'b0, 1'b0, 1'b0));
    check_obs("acc_clr0", 3, ow(9'h000, 1'b1, 1'b0, 1'b0));

    // Shifts
    obs_q.delete();
    send(3'b101, 8'h81, 8'h01, 1'b0);
    send(3'b101, 8'h81, 8'h09, 1'b0);
    send(3'b110, 8'h81, 8'h07, 1'b0);
    wait_drain("shift_drain");
    check_obs("shl_1", 0, ow(9'h102, 1'b0, 1'b0, 1'b0));
    check_obs("shl_9", 1, ow(9'h102, 1'b0, 1'b0, 1'b0));
    check_obs("shr_7", 2, ow(9'h001, 1'b0, 1'b0, 1'b0));

    // Backpressure: two accepts fill the pipe, outputs hold, then drain in order
    obs_q.delete();
    out_ready = 1'b0;
    opcode = 3'b100;
    acc_clr = 1'b0;
    in_valid = 1'b1;
    a = 8'h0F;
    b = 8'hFF;
    @(negedge clk);
    check("bp_accept0", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    a = 8'hAA;
    b = 8'h55;
    @(negedge clk);
    check("bp_accept1", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    a = 8'h01;
    b = 8'h01;
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 0);
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_result", 32'(result), 32'h0F0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_back", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain("bp_drain");
    check("bp_count", 32'(obs_q.size()), 3);
    check_obs("bp_0", 0, ow(9'h0F0, 1'b0, 1'b0, 1'b0));
    check_obs("bp_1", 1, ow(9'h0FF, 1'b0, 1'b0, 1'b0));
    check_obs("bp_2", 2, ow(9'h000, 1'b1, 1'b0, 1'b0));

    // Reset with two transactions in flight
    obs_q.delete();
    send(3'b111, 8'h09, 8'h00, 1'b1);
    send(3'b000, 8'h01, 8'h02, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_result", 32'(result), 0);
    check("midrst_in_ready_after", 32'(in_ready), 0);
    rst = 1'b0;
    send(3'b111, 8'h03, 8'h00, 1'b0);
    wait_drain("midrst_drain");
    check("midrst_count", 32'(obs_q.size()), 1);
    check_obs("midrst_acc", 0, ow(9'h003, 1'b0, 1'b0, 1'b0));

    // Randomized traffic with random backpressure and one mid-stream reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      opcode    = 3'($urandom_range(0, 7));
      a         = W'($urandom);
      b         = W'($urandom);
      acc_clr   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      rst       = (cyc == 1500);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("rand_drain");
    check("rand_queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
